// File: rtl/seqgame_uc.sv
`default_nettype none
// ============================================================================
// Module      : seqgame_uc
// Description : Control unit for show-then-repeat memory games (RAM fill,
//               sequence show, play compare, lives and round bookkeeping).
// Revision    : 1.0 - initial release
// ============================================================================
module seqgame_uc #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 1,
    parameter int ADDR_W   = 4,
    parameter int LIVES    = 3,
    parameter int LIVES_W  = 2,
    parameter int GROW     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               half_show,
    input  logic               end_show,
    input  logic               timeout,
    input  logic               has_play,
    input  logic               correct_play,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               enable_ram,
    output logic               clear_ram,
    output logic               reset_random,
    output logic               clear_reg,
    output logic               enable_reg,
    output logic               clear_show_counter,
    output logic               enable_show_counter,
    output logic               clear_timeout_counter,
    output logic               enable_timeout_counter,
    output logic               clear_points_counter,
    output logic               enable_points_counter,
    output logic [1:0]         out_sel,
    output logic [LIVES_W-1:0] lives_left,
    output logic               round_done,
    output logic               won,
    output logic               lost,
    output logic               finished,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'h0,
        S_PREP      = 4'h1,
        S_GEN       = 4'h2,
        S_SHOW_LEAD = 4'h3,
        S_SHOW_ON   = 4'h4,
        S_SHOW_OFF  = 4'h5,
        S_SHOW_NEXT = 4'h6,
        S_PLAY_INIT = 4'h7,
        S_WAIT_PLAY = 4'h8,
        S_REG_PLAY  = 4'h9,
        S_CMP       = 4'hA,
        S_HIT       = 4'hB,
        S_MISS      = 4'hC,
        S_ROUND_WIN = 4'hD,
        S_END       = 4'hE
    } state_t;

    localparam logic [ADDR_W:0]    c_len_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]    c_max_len   = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]    c_first_len = (GROW != 0) ? (ADDR_W+1)'(INIT_LEN)
                                                             : (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
    localparam logic [LIVES_W-1:0] c_lives     = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] c_life_one  = LIVES_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     round_len_q, round_len_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic                won_q, won_d;
    logic                lost_q, lost_d;

    logic                w_idx_last;
    logic                w_gen_more;

    assign w_idx_last = ({1'b0, idx_q} == (round_len_q - c_len_one));
    assign w_gen_more = (({1'b0, wr_ptr_q} + c_len_one) < round_len_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            idx_q       <= '0;
            round_len_q <= '0;
            lives_q     <= c_lives;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            idx_q       <= idx_d;
            round_len_q <= round_len_d;
            lives_q     <= lives_d;
            won_q       <= won_d;
            lost_q      <= lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        round_len_d = round_len_q;
        lives_d     = lives_q;
        won_d       = won_q;
        lost_d      = lost_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_PREP;
            S_PREP: begin
                lives_d     = c_lives;
                wr_ptr_d    = '0;
                idx_d       = '0;
                won_d       = 1'b0;
                lost_d      = 1'b0;
                round_len_d = c_first_len;
                state_d     = S_GEN;
            end
            S_GEN: begin
                wr_ptr_d = wr_ptr_q + c_addr_one;
                if (!w_gen_more) state_d = S_SHOW_LEAD;
            end
            S_SHOW_LEAD: begin
                if (half_show) begin
                    idx_d   = '0;
                    state_d = S_SHOW_ON;
                end
            end
            S_SHOW_ON:  if (half_show) state_d = S_SHOW_OFF;
            S_SHOW_OFF: if (end_show)  state_d = S_SHOW_NEXT;
            S_SHOW_NEXT: begin
                if (w_idx_last) begin
                    state_d = S_PLAY_INIT;
                end else begin
                    idx_d   = idx_q + c_addr_one;
                    state_d = S_SHOW_ON;
                end
            end
            S_PLAY_INIT: begin
                idx_d   = '0;
                state_d = S_WAIT_PLAY;
            end
            S_WAIT_PLAY: begin
                if (has_play)     state_d = S_REG_PLAY;
                else if (timeout) state_d = S_MISS;
            end
            S_REG_PLAY: state_d = S_CMP;
            S_CMP:      state_d = correct_play ? S_HIT : S_MISS;
            S_HIT: begin
                if (w_idx_last) begin
                    state_d = S_ROUND_WIN;
                end else begin
                    idx_d   = idx_q + c_addr_one;
                    state_d = S_WAIT_PLAY;
                end
            end
            S_MISS: begin
                // The last life ends the game; otherwise replay without rewriting RAM.
                lives_d = lives_q - c_life_one;
                if (lives_q == c_life_one) begin
                    lost_d  = 1'b1;
                    state_d = S_END;
                end else begin
                    state_d = S_SHOW_LEAD;
                end
            end
            S_ROUND_WIN: begin
                if ((GROW == 0) || (round_len_q == c_max_len)) begin
                    won_d   = 1'b1;
                    state_d = S_END;
                end else begin
                    // Next GEN pass starts at the old length so only one element is added.
                    wr_ptr_d    = round_len_q[ADDR_W-1:0];
                    round_len_d = round_len_q + c_len_one;
                    state_d     = S_GEN;
                end
            end
            S_END:   if (start) state_d = S_PREP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable_ram             = 1'b0;
        clear_ram              = 1'b0;
        reset_random           = 1'b0;
        clear_reg              = 1'b0;
        enable_reg             = 1'b0;
        clear_show_counter     = 1'b0;
        enable_show_counter    = 1'b0;
        clear_timeout_counter  = 1'b0;
        enable_timeout_counter = 1'b0;
        clear_points_counter   = 1'b0;
        enable_points_counter  = 1'b0;
        out_sel                = 2'b00;
        round_done             = 1'b0;
        finished               = 1'b0;
        case (state_q)
            S_IDLE: begin
                clear_show_counter    = 1'b1;
                clear_timeout_counter = 1'b1;
            end
            S_PREP: begin
                clear_ram            = 1'b1;
                reset_random         = 1'b1;
                clear_reg            = 1'b1;
                clear_show_counter   = 1'b1;
                clear_points_counter = 1'b1;
            end
            S_GEN: begin
                enable_ram         = 1'b1;
                clear_show_counter = 1'b1;
            end
            S_SHOW_LEAD: begin
                enable_show_counter = 1'b1;
                clear_show_counter  = half_show;
            end
            S_SHOW_ON: begin
                enable_show_counter = 1'b1;
                out_sel             = 2'b01;
            end
            S_SHOW_OFF:  enable_show_counter   = 1'b1;
            S_SHOW_NEXT: clear_show_counter    = 1'b1;
            S_PLAY_INIT: clear_timeout_counter = 1'b1;
            S_WAIT_PLAY: begin
                enable_timeout_counter = 1'b1;
                out_sel                = 2'b10;
            end
            S_REG_PLAY: begin
                enable_reg = 1'b1;
                out_sel    = 2'b10;
            end
            S_CMP: out_sel = 2'b10;
            S_HIT: begin
                clear_timeout_counter = 1'b1;
                enable_points_counter = 1'b1;
                out_sel               = 2'b10;
            end
            S_MISS: begin
                clear_show_counter = 1'b1;
                out_sel            = 2'b10;
            end
            S_ROUND_WIN: begin
                round_done = 1'b1;
                out_sel    = 2'b10;
            end
            S_END: begin
                finished = 1'b1;
                out_sel  = 2'b10;
            end
            default: ;
        endcase
    end

    assign mem_addr   = (state_q == S_GEN) ? wr_ptr_q : idx_q;
    assign lives_left = lives_q;
    assign won        = won_q;
    assign lost       = lost_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seqgame_uc.sv
`default_nettype none
// ============================================================================
// Module      : tb_seqgame_uc
// Description : Directed bench for seqgame_uc: a fixed-length and a growing
//               instance checked each cycle against a game-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seqgame_uc;

    localparam int c_LIVES = 3;
    localparam int c_MAXL [2] = '{4, 3};
    localparam int c_GROW [2] = '{0, 1};

    typedef struct {
        int st; int wr; int idx; int len; int lives; bit won; bit lost;
    } mdl_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [10:0] strobes;
        logic [1:0] osel;
        logic [1:0] lives;
        logic rdone; logic won; logic lost; logic fin;
        logic [3:0] st;
    } obs_t;

    logic clock;
    logic rst_i [2], start_i [2], hs_i [2], es_i [2], to_i [2], hp_i [2], cp_i [2];
    logic [3:0] addr_o [2];
    logic en_ram_o [2], clr_ram_o [2], rst_rnd_o [2], clr_reg_o [2], en_reg_o [2];
    logic clr_show_o [2], en_show_o [2], clr_to_o [2], en_to_o [2], clr_pts_o [2], en_pts_o [2];
    logic [1:0] osel_o [2];
    logic [1:0] lives_o [2];
    logic rdone_o [2], won_o [2], lost_o [2], fin_o [2];
    logic [3:0] st_o [2];

    seqgame_uc #(.MAX_LEN(4), .INIT_LEN(1), .ADDR_W(4), .LIVES(3), .LIVES_W(2), .GROW(0)) u_dut_fixed (
        .clock(clock), .reset(rst_i[0]), .start(start_i[0]), .half_show(hs_i[0]), .end_show(es_i[0]),
        .timeout(to_i[0]), .has_play(hp_i[0]), .correct_play(cp_i[0]), .mem_addr(addr_o[0]),
        .enable_ram(en_ram_o[0]), .clear_ram(clr_ram_o[0]), .reset_random(rst_rnd_o[0]),
        .clear_reg(clr_reg_o[0]), .enable_reg(en_reg_o[0]), .clear_show_counter(clr_show_o[0]),
        .enable_show_counter(en_show_o[0]), .clear_timeout_counter(clr_to_o[0]),
        .enable_timeout_counter(en_to_o[0]), .clear_points_counter(clr_pts_o[0]),
        .enable_points_counter(en_pts_o[0]), .out_sel(osel_o[0]), .lives_left(lives_o[0]),
        .round_done(rdone_o[0]), .won(won_o[0]), .lost(lost_o[0]), .finished(fin_o[0]), .state(st_o[0]));

    seqgame_uc #(.MAX_LEN(3), .INIT_LEN(1), .ADDR_W(4), .LIVES(3), .LIVES_W(2), .GROW(1)) u_dut_grow (
        .clock(clock), .reset(rst_i[1]), .start(start_i[1]), .half_show(hs_i[1]), .end_show(es_i[1]),
        .timeout(to_i[1]), .has_play(hp_i[1]), .correct_play(cp_i[1]), .mem_addr(addr_o[1]),
        .enable_ram(en_ram_o[1]), .clear_ram(clr_ram_o[1]), .reset_random(rst_rnd_o[1]),
        .clear_reg(clr_reg_o[1]), .enable_reg(en_reg_o[1]), .clear_show_counter(clr_show_o[1]),
        .enable_show_counter(en_show_o[1]), .clear_timeout_counter(clr_to_o[1]),
        .enable_timeout_counter(en_to_o[1]), .clear_points_counter(clr_pts_o[1]),
        .enable_points_counter(en_pts_o[1]), .out_sel(osel_o[1]), .lives_left(lives_o[1]),
        .round_done(rdone_o[1]), .won(won_o[1]), .lost(lost_o[1]), .finished(fin_o[1]), .state(st_o[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks, errors, cyc;
    bit chk_en;
    mdl_t m [2];
    bit rst_req [2], start_req [2];
    int act [2][16];      // 0 correct, 1 wrong, 2 timeout, 3 has_play+timeout (correct)
    int act_n [2], act_p [2], last_act [2];
    int cnt_ram [2], cnt_show [2], cnt_pts [2], cnt_rd [2], cnt_reg [2], cnt_clrpts [2];
    int run [2], max_run [2];
    logic [31:0] ram_log [2];
    bit prev_on [2];

    // Game rules applied once per clock edge.
    function automatic mdl_t step(mdl_t m0, int k, bit rs, bit st, bit hs, bit es, bit to, bit hp, bit cp);
        mdl_t n = m0;
        if (rs) begin
            n.st = 0; n.wr = 0; n.idx = 0; n.len = 0; n.lives = c_LIVES; n.won = 0; n.lost = 0;
            return n;
        end
        case (m0.st)
            0, 14: if (st) n.st = 1;
            1: begin
                n.lives = c_LIVES; n.wr = 0; n.idx = 0; n.won = 0; n.lost = 0;
                n.len = (c_GROW[k] != 0) ? 1 : c_MAXL[k];
                n.st = 2;
            end
            2: begin n.wr = (m0.wr + 1) % 16; if (m0.wr + 1 >= m0.len) n.st = 3; end
            3: if (hs) begin n.st = 4; n.idx = 0; end
            4: if (hs) n.st = 5;
            5: if (es) n.st = 6;
            6: if (m0.idx == m0.len - 1) n.st = 7; else begin n.idx = m0.idx + 1; n.st = 4; end
            7: begin n.idx = 0; n.st = 8; end
            8: if (hp) n.st = 9; else if (to) n.st = 12;
            9: n.st = 10;
            10: n.st = cp ? 11 : 12;
            11: if (m0.idx == m0.len - 1) n.st = 13; else begin n.idx = m0.idx + 1; n.st = 8; end
            12: begin
                n.lives = m0.lives - 1;
                if (m0.lives == 1) begin n.lost = 1; n.st = 14; end else n.st = 3;
            end
            13: begin
                if (c_GROW[k] == 0 || m0.len == c_MAXL[k]) begin n.won = 1; n.st = 14; end
                else begin n.len = m0.len + 1; n.st = 2; end
            end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    function automatic bit in_set(int st, logic [15:0] mask);
        return mask[st];
    endfunction

    // Expected outputs from per-state membership masks.
    function automatic obs_t expect_out(mdl_t e, bit hs);
        obs_t o;
        o.addr = (e.st == 2) ? 4'(e.wr) : 4'(e.idx);
        o.strobes = {in_set(e.st, 16'h0004), in_set(e.st, 16'h0002), in_set(e.st, 16'h0002),
                     in_set(e.st, 16'h0002), in_set(e.st, 16'h0200),
                     in_set(e.st, 16'h1047) | (e.st == 3 && hs), in_set(e.st, 16'h0038),
                     in_set(e.st, 16'h0881), in_set(e.st, 16'h0100),
                     in_set(e.st, 16'h0002), in_set(e.st, 16'h0800)};
        o.osel  = (e.st == 4) ? 2'b01 : (in_set(e.st, 16'h7F00) ? 2'b10 : 2'b00);
        o.lives = 2'(e.lives);
        o.rdone = in_set(e.st, 16'h2000);
        o.won   = e.won;
        o.lost  = e.lost;
        o.fin   = in_set(e.st, 16'h4000);
        o.st    = 4'(e.st);
        return o;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            m[k] <= step(m[k], k, rst_i[k], start_i[k], hs_i[k], es_i[k], to_i[k], hp_i[k], cp_i[k]);
    end

    always @(negedge clock) begin
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                obs_t got, exp_o;
                got.addr = addr_o[k];
                got.strobes = {en_ram_o[k], clr_ram_o[k], rst_rnd_o[k], clr_reg_o[k], en_reg_o[k],
                               clr_show_o[k], en_show_o[k], clr_to_o[k], en_to_o[k],
                               clr_pts_o[k], en_pts_o[k]};
                got.osel = osel_o[k]; got.lives = lives_o[k]; got.rdone = rdone_o[k];
                got.won = won_o[k]; got.lost = lost_o[k]; got.fin = fin_o[k]; got.st = st_o[k];
                exp_o = expect_out(m[k], hs_i[k]);
                checks++;
                if (got !== exp_o) begin
                    errors++;
                    $display("FAIL dut%0d outputs @%0t: got %h required %h", k, $time, got, exp_o);
                end
                if (en_ram_o[k]) begin
                    cnt_ram[k]++; ram_log[k] = {ram_log[k][27:0], addr_o[k]}; run[k]++;
                    if (run[k] > max_run[k]) max_run[k] = run[k];
                end else run[k] = 0;
                if (osel_o[k] == 2'b01 && !prev_on[k]) cnt_show[k]++;
                prev_on[k] = (osel_o[k] == 2'b01);
                if (en_pts_o[k])  cnt_pts[k]++;
                if (rdone_o[k])   cnt_rd[k]++;
                if (en_reg_o[k])  cnt_reg[k]++;
                if (clr_pts_o[k]) cnt_clrpts[k]++;
            end
        end
    end

    task automatic drive();
        bit par;
        cyc++;
        par = cyc[0];
        for (int k = 0; k < 2; k++) begin
            int s = m[k].st;
            rst_i[k]   = rst_req[k];
            start_i[k] = (s == 0 || s == 14) ? start_req[k] : (s == 5 || s == 8);
            hs_i[k]    = par;
            es_i[k]    = (s == 5) ? par : ~par;
            to_i[k]    = 1'b1;
            hp_i[k]    = (s == 4);
            cp_i[k]    = (s == 10) ? (last_act[k] == 0 || last_act[k] == 3) : par;
            if (s == 8) begin
                hp_i[k] = 1'b0; to_i[k] = 1'b0;
                if (par && act_p[k] < act_n[k]) begin
                    last_act[k] = act[k][act_p[k]];
                    act_p[k]++;
                    hp_i[k] = (last_act[k] != 2);
                    to_i[k] = (last_act[k] == 2 || last_act[k] == 3);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        drive();
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic wait_st(input int k, input int code, input int budget);
        int n = 0;
        while (m[k].st != code && n < budget) begin tick(); n++; end
        checks++;
        if (m[k].st != code) begin
            errors++;
            $display("FAIL wait dut%0d state %0d: got %0d required %0d", k, code, m[k].st, code);
        end
    endtask

    task automatic load(input int k, input int n, input logic [31:0] codes);
        for (int i = 0; i < n; i++) act[k][i] = int'(codes[4*(n-1-i) +: 4]);
        act_n[k] = n; act_p[k] = 0;
    endtask

    task automatic start_game(input int k);
        start_req[k] = 1'b1; tick(); start_req[k] = 1'b0;
    endtask

    int b_show, b_pts, b_reg;

    initial begin
        checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst_req[k] = 1'b1; start_req[k] = 1'b0; act_n[k] = 0; act_p[k] = 0; last_act[k] = 0;
            ram_log[k] = '0; prev_on[k] = 1'b0;
            cnt_ram[k] = 0; cnt_show[k] = 0; cnt_pts[k] = 0; cnt_rd[k] = 0; cnt_reg[k] = 0;
            cnt_clrpts[k] = 0; run[k] = 0; max_run[k] = 0;
        end
        drive();
        tick(); tick();
        rst_req[0] = 1'b0; rst_req[1] = 1'b0;
        chk_en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.state%0d", k), st_o[k], 0);
            chk($sformatf("reset.lives%0d", k), lives_o[k], 3);
            chk($sformatf("reset.out_sel%0d", k), osel_o[k], 0);
            chk($sformatf("reset.flags%0d", k), {won_o[k], lost_o[k]}, 0);
        end

        // Fixed-length game of 4, all plays correct.
        load(0, 4, 32'h0300);
        b_show = cnt_show[0]; b_pts = cnt_pts[0]; b_reg = cnt_reg[0];
        start_game(0);
        wait_st(0, 14, 400);
        chk("fixed.ram_writes", cnt_ram[0], 4);
        chk("fixed.ram_addrs", int'(ram_log[0][15:0]), 16'h0123);
        chk("fixed.ram_consecutive", max_run[0], 4);
        chk("fixed.show_windows", cnt_show[0] - b_show, 4);
        chk("fixed.points", cnt_pts[0] - b_pts, 4);
        chk("fixed.loads", cnt_reg[0] - b_reg, 4);
        chk("fixed.won", won_o[0], 1);
        chk("fixed.finished", fin_o[0], 1);
        chk("fixed.state", st_o[0], 14);

        // Growing game 1/2/3 with one wrong play in round 2.
        load(1, 8, 32'h00100000);
        b_show = cnt_show[1]; b_pts = cnt_pts[1];
        start_game(1);
        wait_st(1, 12, 400);
        chk("miss.lives_before", lives_o[1], 3);
        tick();
        chk("miss.state_after", st_o[1], 3);
        chk("miss.lives_after", lives_o[1], 2);
        chk("miss.ram_writes", cnt_ram[1], 2);
        wait_st(1, 14, 800);
        chk("grow.ram_writes", cnt_ram[1], 3);
        chk("grow.ram_addrs", int'(ram_log[1][11:0]), 12'h012);
        chk("grow.round_done", cnt_rd[1], 3);
        chk("grow.show_windows", cnt_show[1] - b_show, 8);
        chk("grow.points", cnt_pts[1] - b_pts, 7);
        chk("grow.points_clears", cnt_clrpts[1], 1);
        chk("grow.won", won_o[1], 1);
        chk("grow.lives", lives_o[1], 2);

        // Restart from END, then lose every life by timeout.
        load(1, 3, 32'h222);
        start_game(1);
        tick(); tick();
        chk("restart.state", st_o[1], 2);
        chk("restart.flags", {won_o[1], lost_o[1]}, 0);
        chk("restart.lives", lives_o[1], 3);
        wait_st(1, 14, 400);
        repeat (3) tick();
        chk("lose.lives", lives_o[1], 0);
        chk("lose.lost", lost_o[1], 1);
        chk("lose.won", won_o[1], 0);
        chk("lose.out_sel", osel_o[1], 2);
        chk("lose.state", st_o[1], 14);

        // Reset while the fixed instance shows the first element.
        load(0, 0, 32'h0);
        start_game(0);
        wait_st(0, 4, 200);
        chk("rst.out_sel_before", osel_o[0], 1);
        rst_req[0] = 1'b1; rst_i[0] = 1'b1;
        rst_req[0] = 1'b0;
        tick();
        chk("rst.state", st_o[0], 0);
        chk("rst.out_sel", osel_o[0], 0);
        chk("rst.lives", lives_o[0], 3);
        chk("rst.flags", {won_o[0], lost_o[0], fin_o[0]}, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
